// File: rtl/noc_rr_port_arbiter_if.sv
// Handshake bundle between N requesters, the round-robin port arbiter and
// the downstream stage. The master modport is the arbiter side; the slave
// modport is the requester/downstream side.
interface noc_rr_port_arbiter_if #(
  parameter int N     = 4,
  parameter int WIDTH = 8
);
  localparam int SRC_W = $clog2(N);

  logic [N-1:0]       req_valid;
  logic [N*WIDTH-1:0] req_data;
  logic [N-1:0]       req_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [SRC_W-1:0]   out_src;
  logic               out_ready;
  logic               busy;

  modport master (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_src, busy
  );

  modport slave (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_src, busy
  );
endinterface

// File: rtl/noc_rr_port_arbiter.sv
// Round-robin arbiter for one shared NoC router output port.
// IDLE picks the first valid requester starting at rr_ptr, strobes its
// req_ready and registers the flit; SEND holds the flit until out_ready.
// Optional per-requester saturating grant counters: define ARB_STATS_EN.

`ifdef ARB_STATS_EN
// Saturating grant counter for one requester.
module noc_rr_grant_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q;

  // count grants, stick at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (rst)                        cnt_q <= '0;
    else if (inc_i && cnt_q != '1)  cnt_q <= cnt_q + CNT_W'(1);
  end

  assign cnt_o = cnt_q;
endmodule
`endif

module noc_rr_port_arbiter #(
  parameter int N     = 4,
  parameter int WIDTH = 8
`ifdef ARB_STATS_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  noc_rr_port_arbiter_if.master    bus
`ifdef ARB_STATS_EN
  ,
  output logic [N*CNT_W-1:0]       grant_count
`endif
);
  localparam int SRC_W = $clog2(N);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic [SRC_W-1:0]   out_src_q, out_src_d;

  logic [SRC_W-1:0]   grant_idx;
  logic               grant_any;
  logic               grant_fire;
  logic [WIDTH-1:0]   grant_flit;
  logic [N-1:0]       ready_vec;

  // rotating priority search: walk from the farthest slot back to rr_ptr so
  // the last hit (the one nearest rr_ptr) is the winner
  always_comb begin
    logic [SRC_W-1:0] idx;
    grant_any = 1'b0;
    grant_idx = rr_ptr_q;
    idx       = '0;
    for (int k = N-1; k >= 0; k--) begin
      idx = rr_ptr_q + SRC_W'(k);
      if (bus.req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = idx;
      end
    end
  end

  assign grant_fire = (state_q == IDLE) && grant_any;

  // flit mux for the winning requester
  always_comb begin
    grant_flit = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == SRC_W'(i)) grant_flit = bus.req_data[i*WIDTH +: WIDTH];
    end
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      out_data_q <= '0;
      out_src_q  <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      out_data_q <= out_data_d;
      out_src_q  <= out_src_d;
    end
  end

  // next state: a grant moves to SEND, downstream acceptance returns to IDLE
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    out_data_d = out_data_q;
    out_src_d  = out_src_q;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          state_d    = SEND;
          rr_ptr_d   = grant_idx + SRC_W'(1);  // wraps naturally, N is 2^k
          out_data_d = grant_flit;
          out_src_d  = grant_idx;
        end
      end
      SEND: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // outputs: one-hot accept strobe only while granting in IDLE
  always_comb begin
    ready_vec = '0;
    for (int i = 0; i < N; i++) begin
      ready_vec[i] = grant_fire && (grant_idx == SRC_W'(i));
    end
    bus.req_ready = ready_vec;
    bus.out_valid = (state_q == SEND);
    bus.busy      = (state_q == SEND);
    bus.out_data  = out_data_q;
    bus.out_src   = out_src_q;
  end

`ifdef ARB_STATS_EN
  // one saturating counter per requester, bumped by its accept strobe
  for (genvar g = 0; g < N; g++) begin : g_cnt
    noc_rr_grant_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc_i (ready_vec[g]),
      .cnt_o (grant_count[g*CNT_W +: CNT_W])
    );
  end
`endif
endmodule

// File: tb/tb_noc_rr_port_arbiter.sv
// Directed bench for noc_rr_port_arbiter. Inputs change 1 time unit after
// the rising edge; outputs are sampled on the falling edge.
module tb_noc_rr_port_arbiter;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

`ifdef ARB_STATS_EN
  localparam int CNT_W = 2;
  logic [4*CNT_W-1:0] grant_count;
`endif

  noc_rr_port_arbiter_if #(.N(4), .WIDTH(8)) bus ();

  noc_rr_port_arbiter #(
    .N(4),
    .WIDTH(8)
`ifdef ARB_STATS_EN
    ,
    .CNT_W(CNT_W)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ARB_STATS_EN
    ,
    .grant_count (grant_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] rr_dat [4];

  initial begin
    errors = 0;
    checks = 0;
    rr_dat = '{8'h10, 8'h21, 8'h32, 8'h43};
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b0;

    // reset for 2 cycles
    step();
    @(negedge clk);
    chk("rst_state", {bus.out_valid, bus.busy, bus.req_ready, bus.out_src, bus.out_data},
        32'h0);
    step();
    rst = 1'b0;

    // idle for 10 cycles
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("idle", {bus.out_valid, bus.busy, bus.req_ready, bus.out_src}, 32'h0);
      step();
    end

    // single flit from requester 2
    bus.req_valid = 4'b0100;
    bus.req_data[2*8 +: 8] = 8'hA3;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("one_ready", bus.req_ready, 32'h4);
    step();
    bus.req_valid = '0;
    @(negedge clk);
    chk("one_valid", bus.out_valid, 32'h1);
    chk("one_data",  bus.out_data,  32'hA3);
    chk("one_src",   bus.out_src,   32'h2);
    chk("one_ready_send", bus.req_ready, 32'h0);
    step();
    @(negedge clk);
    chk("one_idle", {bus.out_valid, bus.busy}, 32'h0);

    // re-centre rr_ptr at 0 for the fairness run
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;

    // round robin with all four requesters held valid
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) bus.req_data[i*8 +: 8] = rr_dat[i];
    bus.out_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      chk("rr_ready", bus.req_ready, 32'(1 << (n % 4)));
      step();
      if (n == 5) bus.req_valid = '0;
      @(negedge clk);
      chk("rr_src",  bus.out_src,  32'(n % 4));
      chk("rr_data", bus.out_data, 32'(rr_dat[n % 4]));
      step();
    end
    // rr_ptr now 2

    // backpressure: requester 3 wins (pointer at 2, 2 idle), then stall
    bus.req_valid = 4'b1000;
    bus.req_data[3*8 +: 8] = 8'hC6;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("bp_ready", bus.req_ready, 32'h8);
    step();
    bus.req_valid = 4'b0001;  // requester 0 waits behind the stalled flit
    for (int c = 0; c < 6; c++) begin
      if (c == 5) bus.out_ready = 1'b1;
      @(negedge clk);
      chk("bp_hold", {bus.out_valid, bus.busy, bus.out_src, bus.out_data, bus.req_ready},
          {2'b11, 2'd3, 8'hC6, 4'h0});
      step();
    end
    @(negedge clk);
    chk("bp_next_ready", {bus.out_valid, bus.req_ready}, 32'h1);
    step();
    bus.req_valid = '0;
    @(negedge clk);
    chk("bp_next_src",  bus.out_src,  32'h0);
    chk("bp_next_data", bus.out_data, 32'h10);
    step();
    // rr_ptr now 1

    // reset mid-SEND discards the flit and re-centres rr_ptr
    bus.req_valid = 4'b0010;
    bus.req_data[1*8 +: 8] = 8'h5F;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("ms_ready", bus.req_ready, 32'h2);
    step();
    bus.req_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    chk("ms_send", {bus.out_valid, bus.out_data}, {1'b1, 8'h5F});
    step();
    rst = 1'b0;
    bus.req_valid = 4'b0111;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) bus.req_data[i*8 +: 8] = rr_dat[i];
    @(negedge clk);
    chk("ms_dropped", {bus.out_valid, bus.busy}, 32'h0);
    chk("ms_first_ready", bus.req_ready, 32'h1);
    step();
    bus.req_valid = '0;
    @(negedge clk);
    chk("ms_first_src",  bus.out_src,  32'h0);
    chk("ms_first_data", bus.out_data, 32'h10);
    step();

`ifdef ARB_STATS_EN
    // requester 1 granted 5 times with a 2-bit counter -> saturates at 3
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.req_valid = 4'b0010;
    bus.req_data[1*8 +: 8] = 8'h99;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("st_clear", grant_count, 32'h0);
    repeat (6) step();
    @(negedge clk);
    chk("st_three", grant_count, 32'h0C);
    repeat (4) step();
    bus.req_valid = '0;
    @(negedge clk);
    chk("st_sat", grant_count, 32'h0C);
    step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/noc_rr_port_arbiter.md
Name: noc_rr_port_arbiter

Overview:
- Clocked round-robin arbiter/scheduler for one shared NoC router output port.
- Accepts 8-bit flits ({data[7:4], addr[3:0]}) from N requesters, i.e. the input ports feeding one output.
- Grants one requester at a time and registers the selected flit.
- Presents the flit on a single valid/ready output channel toward the downstream split/core stage.
- Guarantees fairness: no requester waits more than N-1 grants while holding valid.

Parameters:
- N, 4, number of requesters; power of two, 2..16.
- WIDTH, 8, flit width in bits.
- CNT_W, 16, width of each per-requester grant counter (optional feature only).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active-high.
- req_valid  input  N  requester i has a flit pending.
- req_data  input  N*WIDTH  flit of requester i in bits [i*WIDTH +: WIDTH].
- req_ready  output  N  one-hot (or zero) accept strobe to requester i.
- out_valid  output  1  registered flit available.
- out_data  output  WIDTH  registered flit.
- out_src  output  $clog2(N)  index of the requester that supplied out_data.
- out_ready  input  1  downstream accepts the flit.
- busy  output  1  high in SEND state.
- grant_count  output  N*CNT_W  present only with ARB_STATS_EN.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - out_valid=0, out_data=0, out_src=0, busy=0, req_ready=0.
  - rr_ptr=0, state=IDLE, grant_count=0.
- States are IDLE and SEND.
- IDLE:
  - Grant index g = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod N.
  - req_ready[g]=1 combinationally in that same cycle. All other req_ready bits are 0.
  - On the clock edge: out_data<=req_data[g], out_src<=g, out_valid<=1, rr_ptr<=(g+1) mod N, state<=SEND.
  - If no req_valid bit is set, remain in IDLE with all outputs unchanged and out_valid=0.
- SEND:
  - req_ready=0, busy=1, out_valid=1.
  - out_data and out_src are held stable until out_ready=1.
  - On a cycle with out_ready=1: out_valid<=0, state<=IDLE.
  - No new grant occurs in the SEND cycle.
- Timing:
  - Latency from req_valid (with the arbiter in IDLE) to out_valid: 1 cycle.
  - Peak throughput: 1 flit per 2 cycles.
- Requester protocol:
  - Hold req_valid and req_data stable until req_ready is sampled high.
  - Deasserting req_valid before ready is a protocol violation. Behaviour is undefined and the arbiter does not check it.
- rr_ptr update: rr_ptr advances only on a grant and wraps from N-1 to 0.
- Simultaneous requests: the requester nearest rr_ptr wins. A requester that just won becomes lowest priority.
- Single requester continuously valid: it is granted every IDLE cycle, i.e. every 2nd cycle when out_ready is held 1.
- Reset mid-SEND: the held flit is discarded, out_valid drops on the next edge, and no handshake completes.
- Reset asserted in the same cycle as a grant: reset wins. req_ready may be combinationally high in that cycle, but the flit is not captured, so the bench treats it as not consumed.
- out_ready in IDLE is ignored.

Optional Feature:
- Macro: ARB_STATS_EN.
- Defined:
  - grant_count[i*CNT_W +: CNT_W] increments on every grant to requester i.
  - Counters saturate at 2^CNT_W-1 (no wrap).
  - Counters clear on rst.
- Undefined: the grant_count port and its counters are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then all req_valid=0 for 10 cycles -> out_valid=0, req_ready=0, busy=0, out_src=0 throughout.
- Single flit:
  - req_valid=4'b0100, req_data[2]=8'hA3, out_ready=1.
  - Required: req_ready=4'b0100 in cycle 0; out_valid=1, out_data=8'hA3, out_src=2 in cycle 1; IDLE in cycle 2.
- Round-robin fairness:
  - req_valid=4'b1111 held (each requester re-presents after its ready), flits 8'h10/8'h21/8'h32/8'h43 on requesters 0..3, out_ready=1.
  - Required: grant order 0,1,2,3,0,1 with out_data 10,21,32,43,10,21.
- Backpressure:
  - One flit in SEND, out_ready=0 for 5 cycles, then 1.
  - Required: out_valid, out_data and out_src stable for all 6 cycles; req_ready=0 throughout; next grant on the cycle after acceptance.
- Reset mid-SEND: flit 8'h5F in SEND with out_ready=0, rst=1 for 1 cycle -> next cycle out_valid=0, rr_ptr=0, and requester 0 is granted first afterwards.
- ARB_STATS_EN with CNT_W=2: requester 1 granted 5 times -> grant_count for requester 1 reads 3 (saturated); other counters read 0.
